// File: rtl/fwnoc_router_egress_sched_if.sv
// Egress scheduler bus: ingress requests and header size codes in,
// one-hot egress grant and packet status out.
//   req        [3:0]  per-ingress packet request
//   hdr_sz     [15:0] 4-bit header size code per ingress (n at [4n+3:4n])
//   xfer              egress flit accepted this cycle
//   cfg_weight [7:0]  2-bit weight per ingress (weighted build only)
//   gnt        [3:0]  registered one-hot grant, 0 when idle
//   busy              packet connection held
//   pkt_done          pulse the cycle after the last flit
//   sz_err            pulse with the grant of an illegal size code
// master = ingress/egress side driving requests; slave = scheduler.
interface fwnoc_router_egress_sched_if;
  logic [3:0]  req;
  logic [15:0] hdr_sz;
  logic        xfer;
  logic [7:0]  cfg_weight;
  logic [3:0]  gnt;
  logic        busy;
  logic        pkt_done;
  logic        sz_err;

  modport master (
    output req, hdr_sz, xfer, cfg_weight,
    input  gnt, busy, pkt_done, sz_err
  );

  modport slave (
    input  req, hdr_sz, xfer, cfg_weight,
    output gnt, busy, pkt_done, sz_err
  );
endinterface

// File: rtl/fwnoc_router_egress_sched.sv
// Packet-atomic egress scheduler for a 4-ingress NoC router port.
// Grants one ingress per packet (round-robin from last_port+1), holds the
// grant until header + payload flits have transferred, then drops to IDLE
// for at least one cycle before the next grant.
// Ports:
//   clock  - sole clock, rising edge
//   reset  - asynchronous, active low
//   bus    - fwnoc_router_egress_sched_if.slave (req/hdr_sz/xfer/cfg_weight
//            in; gnt/busy/pkt_done/sz_err out)
// Build option:
//   FWNOC_EGRESS_SCHED_WEIGHT_EN - weighted arbitration: a port may be
//   re-granted up to cfg_weight extra consecutive packets.
module fwnoc_router_egress_sched (
  input logic                          clock,
  input logic                          reset,
  fwnoc_router_egress_sched_if.slave   bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [4:0]  rem_q, rem_d;
  logic [1:0]  last_q, last_d;
  logic        pkt_done_q, pkt_done_d;
  logic        sz_err_q, sz_err_d;

  logic [1:0]  rr_port;
  logic [1:0]  win;
  logic [3:0]  win_code;

`ifdef FWNOC_EGRESS_SCHED_WEIGHT_EN
  logic [1:0]  wcnt_q, wcnt_d;
`else
  logic        unused_cfg;
  assign unused_cfg = ^bus.cfg_weight;
`endif

  // Payload flits following the header; codes 6..15 are illegal and
  // carry no payload so the header alone closes the packet.
  function automatic logic [4:0] payload(input logic [3:0] code);
    case (code)
      4'd1:    payload = 5'd1;
      4'd2:    payload = 5'd2;
      4'd3:    payload = 5'd4;
      4'd4:    payload = 5'd8;
      4'd5:    payload = 5'd16;
      default: payload = 5'd0;
    endcase
  endfunction

  // Round-robin search. Scan from farthest to nearest offset so the
  // nearest requester above last_port wins; offset 4 (last_port itself)
  // has the lowest priority.
  always_comb begin
    rr_port = last_q;
    for (int i = 4; i >= 1; i--) begin
      if (bus.req[last_q + 2'(i)]) rr_port = last_q + 2'(i);
    end
  end

`ifdef FWNOC_EGRESS_SCHED_WEIGHT_EN
  // Remaining weight lets the previous winner keep the port.
  assign win = (wcnt_q != 2'd0 && bus.req[last_q]) ? last_q : rr_port;
`else
  assign win = rr_port;
`endif

  assign win_code = bus.hdr_sz[{win, 2'b00} +: 4];

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rem_d      = rem_q;
    last_d     = last_q;
    pkt_done_d = 1'b0;
    sz_err_d   = 1'b0;
`ifdef FWNOC_EGRESS_SCHED_WEIGHT_EN
    wcnt_d     = wcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d  = BUSY;
          gnt_d    = 4'b0001 << win;
          rem_d    = payload(win_code);
          sz_err_d = (win_code > 4'd5);
          last_d   = win;
`ifdef FWNOC_EGRESS_SCHED_WEIGHT_EN
          if (win != last_q)
            wcnt_d = bus.cfg_weight[{win, 1'b0} +: 2];
          else if (wcnt_q != 2'd0)
            wcnt_d = wcnt_q - 2'd1;
`endif
        end
      end
      BUSY: begin
        if (bus.xfer) begin
          if (rem_q != 5'd0) begin
            rem_d = rem_q - 5'd1;
          end else begin
            state_d    = IDLE;
            gnt_d      = 4'b0000;
            pkt_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      gnt_q      <= 4'b0000;
      rem_q      <= 5'd0;
      last_q     <= 2'd3;
      pkt_done_q <= 1'b0;
      sz_err_q   <= 1'b0;
`ifdef FWNOC_EGRESS_SCHED_WEIGHT_EN
      wcnt_q     <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rem_q      <= rem_d;
      last_q     <= last_d;
      pkt_done_q <= pkt_done_d;
      sz_err_q   <= sz_err_d;
`ifdef FWNOC_EGRESS_SCHED_WEIGHT_EN
      wcnt_q     <= wcnt_d;
`endif
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.busy     = (state_q == BUSY);
  assign bus.pkt_done = pkt_done_q;
  assign bus.sz_err   = sz_err_q;

endmodule

// File: tb/tb_fwnoc_router_egress_sched.sv
// Self-checking bench for fwnoc_router_egress_sched. Expected packets
// (grant, flit count, size error) are queued when requests are driven and
// popped when the scheduler serves them. Inputs change and outputs are
// sampled on the falling edge.
module tb_fwnoc_router_egress_sched;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fwnoc_router_egress_sched_if bus_if();

  fwnoc_router_egress_sched dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] gnt;
    int         flits;
    bit         err;
  } exp_t;
  exp_t sb[$];

  task automatic do_reset();
    @(negedge clock);
    reset       = 1'b0;
    bus_if.req  = 4'b0;
    bus_if.xfer = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Waits for a grant, then streams flits until the grant drops.
  task automatic serve_packet(input logic [3:0] req_after, output logic [3:0] g,
                              output int flits, output int waits, output bit err,
                              output bit held, output bit done);
    g = 4'b0; flits = 0; waits = 0; err = 1'b0; held = 1'b1; done = 1'b0;
    while (bus_if.gnt == 4'b0 && waits < 20) begin
      @(negedge clock);
      waits++;
    end
    if (bus_if.gnt == 4'b0) return;
    g   = bus_if.gnt;
    err = bus_if.sz_err;
    bus_if.req = req_after;
    while (flits < 40) begin
      bus_if.xfer = 1'b1;
      @(negedge clock);
      flits++;
      if (bus_if.gnt == 4'b0) begin
        done = bus_if.pkt_done;
        break;
      end
      if (bus_if.gnt != g) held = 1'b0;
    end
    bus_if.xfer = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++; if (bus_if.gnt !== 4'b0) begin failures++; $display("FAIL reset_gnt got=%b want=0000", bus_if.gnt); end
    checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus_if.busy); end
    checks++; if (bus_if.pkt_done !== 1'b0) begin failures++; $display("FAIL reset_pkt_done got=%b want=0", bus_if.pkt_done); end
    checks++; if (bus_if.sz_err !== 1'b0) begin failures++; $display("FAIL reset_sz_err got=%b want=0", bus_if.sz_err); end
    reset = 1'b1;
  endtask

  task automatic test_idle_xfer();
    bus_if.req  = 4'b0;
    bus_if.xfer = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (bus_if.gnt !== 4'b0) begin failures++; $display("FAIL idle_xfer_gnt got=%b want=0000", bus_if.gnt); end
    checks++; if (bus_if.busy !== 1'b0 || bus_if.pkt_done !== 1'b0) begin
      failures++; $display("FAIL idle_xfer_status got busy=%b done=%b want 0 0", bus_if.busy, bus_if.pkt_done); end
    bus_if.xfer = 1'b0;
  endtask

  task automatic test_single_port();
    logic [3:0] g; int flits, waits; bit err, held, done; exp_t e;
    do_reset();
    bus_if.hdr_sz = 16'h0003;
    bus_if.req    = 4'b0001;
    sb.push_back('{gnt: 4'b0001, flits: 5, err: 1'b0});
    serve_packet(4'b0000, g, flits, waits, err, held, done);
    e = sb.pop_front();
    checks++; if (g !== e.gnt) begin failures++; $display("FAIL single_gnt got=%b want=%b", g, e.gnt); end
    checks++; if (waits != 1) begin failures++; $display("FAIL single_latency got=%0d want=1", waits); end
    checks++; if (flits != e.flits) begin failures++; $display("FAIL single_flits got=%0d want=%0d", flits, e.flits); end
    checks++; if (held !== 1'b1) begin failures++; $display("FAIL single_held got=%b want=1", held); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL single_pkt_done got=%b want=1", done); end
    checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b want=0", bus_if.busy); end
    @(negedge clock);
    checks++; if (bus_if.pkt_done !== 1'b0 || bus_if.gnt !== 4'b0) begin
      failures++; $display("FAIL single_after got done=%b gnt=%b want 0 0000", bus_if.pkt_done, bus_if.gnt); end
  endtask

  task automatic test_rotation();
    logic [3:0] g; int flits, waits; bit err, held, done; exp_t e;
    logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    bus_if.hdr_sz = 16'h0000;
    bus_if.req    = 4'b1111;
    for (int i = 0; i < 5; i++) sb.push_back('{gnt: order[i], flits: 1, err: 1'b0});
    for (int i = 0; i < 5; i++) begin
      serve_packet(4'b1111, g, flits, waits, err, held, done);
      e = sb.pop_front();
      checks++; if (g !== e.gnt || waits != 1 || flits != e.flits || done !== 1'b1) begin
        failures++;
        $display("FAIL rotation[%0d] got gnt=%b wait=%0d flits=%0d done=%b want gnt=%b wait=1 flits=%0d done=1",
                 i, g, waits, flits, done, e.gnt, e.flits);
      end
    end
    bus_if.req = 4'b0;
  endtask

  task automatic test_atomicity();
    int waits, cnt; bit held; exp_t e;
    do_reset();
    bus_if.hdr_sz = 16'h0500;
    bus_if.req    = 4'b0100;
    sb.push_back('{gnt: 4'b0100, flits: 17, err: 1'b0});
    waits = 0;
    while (bus_if.gnt == 4'b0 && waits < 5) begin @(negedge clock); waits++; end
    e = sb.pop_front();
    checks++; if (bus_if.gnt !== e.gnt) begin failures++; $display("FAIL atomic_gnt got=%b want=%b", bus_if.gnt, e.gnt); end
    cnt = 0; held = 1'b1;
    while (cnt < 40) begin
      bus_if.xfer = 1'b1;
      if (cnt == 3) bus_if.req = 4'b0001;
      @(negedge clock);
      cnt++;
      if (bus_if.gnt == 4'b0) break;
      if (bus_if.gnt !== 4'b0100) held = 1'b0;
    end
    bus_if.xfer = 1'b0;
    checks++; if (held !== 1'b1) begin failures++; $display("FAIL atomic_held got=0 want=1"); end
    checks++; if (cnt != e.flits) begin failures++; $display("FAIL atomic_flits got=%0d want=%0d", cnt, e.flits); end
    checks++; if (bus_if.pkt_done !== 1'b1) begin failures++; $display("FAIL atomic_pkt_done got=%b want=1", bus_if.pkt_done); end
    @(negedge clock);
    checks++; if (bus_if.gnt !== 4'b0001) begin failures++; $display("FAIL atomic_next_gnt got=%b want=0001", bus_if.gnt); end
    bus_if.req = 4'b0;
  endtask

  task automatic test_illegal_code();
    logic [3:0] g; int flits, waits; bit err, held, done; exp_t e;
    logic [15:0] hdr [2] = '{16'h0090, 16'h0F00};
    logic [3:0]  rq  [2] = '{4'b0010, 4'b0100};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      bus_if.hdr_sz = hdr[i];
      bus_if.req    = rq[i];
      sb.push_back('{gnt: rq[i], flits: 1, err: 1'b1});
      serve_packet(4'b0000, g, flits, waits, err, held, done);
      e = sb.pop_front();
      checks++; if (g !== e.gnt || err !== e.err) begin
        failures++; $display("FAIL illegal[%0d]_grant got gnt=%b sz_err=%b want gnt=%b sz_err=1", i, g, err, e.gnt); end
      checks++; if (flits != e.flits || done !== 1'b1) begin
        failures++; $display("FAIL illegal[%0d]_end got flits=%0d done=%b want flits=1 done=1", i, flits, done); end
      checks++; if (bus_if.sz_err !== 1'b0) begin
        failures++; $display("FAIL illegal[%0d]_pulse got sz_err=%b want=0", i, bus_if.sz_err); end
    end
  endtask

  task automatic test_reset_mid();
    int waits;
    do_reset();
    bus_if.hdr_sz = 16'h4000;
    bus_if.req    = 4'b1000;
    waits = 0;
    while (bus_if.gnt == 4'b0 && waits < 5) begin @(negedge clock); waits++; end
    checks++; if (bus_if.gnt !== 4'b1000) begin failures++; $display("FAIL rstmid_gnt got=%b want=1000", bus_if.gnt); end
    bus_if.req  = 4'b0;
    bus_if.xfer = 1'b1;
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    bus_if.xfer = 1'b0;
    #1;
    checks++; if (bus_if.gnt !== 4'b0 || bus_if.busy !== 1'b0) begin
      failures++; $display("FAIL rstmid_async got gnt=%b busy=%b want 0000 0", bus_if.gnt, bus_if.busy); end
    @(negedge clock);
    reset      = 1'b1;
    bus_if.req = 4'b1000;
    @(negedge clock);
    checks++; if (bus_if.gnt !== 4'b1000) begin failures++; $display("FAIL rstmid_regrant got=%b want=1000", bus_if.gnt); end
    bus_if.req = 4'b0;
  endtask

  task automatic test_weights();
    logic [3:0] g; int flits, waits; bit err, held, done; exp_t e;
`ifdef FWNOC_EGRESS_SCHED_WEIGHT_EN
    logic [3:0] order [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
`else
    logic [3:0] order [8] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif
    do_reset();
    bus_if.cfg_weight = 8'b00_00_00_10;
    bus_if.hdr_sz     = 16'h0000;
    bus_if.req        = 4'b0011;
    for (int i = 0; i < 8; i++) sb.push_back('{gnt: order[i], flits: 1, err: 1'b0});
    for (int i = 0; i < 8; i++) begin
      serve_packet(4'b0011, g, flits, waits, err, held, done);
      e = sb.pop_front();
      checks++; if (g !== e.gnt || waits != 1) begin
        failures++; $display("FAIL weights[%0d] got gnt=%b wait=%0d want gnt=%b wait=1", i, g, waits, e.gnt); end
    end
    bus_if.req        = 4'b0;
    bus_if.cfg_weight = 8'b0;
  endtask

  initial begin
    bus_if.req        = 4'b0;
    bus_if.hdr_sz     = 16'h0;
    bus_if.xfer       = 1'b0;
    bus_if.cfg_weight = 8'b0;
    reset             = 1'b0;
    repeat (2) @(negedge clock);
    test_reset();
    test_idle_xfer();
    test_single_port();
    test_rotation();
    test_atomicity();
    test_illegal_code();
    test_reset_mid();
    test_weights();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
